// File: rtl/wb_write_queue_pkg.sv
// Shared constants and queue entry type for the writeback write queue.
// Sized for the 8x16 register file.
package wbq_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rreg;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Producer handshake, register file write port and forwarding read paths.
// The slave modport is the queue; master is the surrounding pipeline.
interface wb_write_queue_if #(
    parameter int unsigned DATA_W = wbq_pkg::DATA_W,
    parameter int unsigned ADDR_W = wbq_pkg::ADDR_W
);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              rf_stall;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_wreg;
    logic [DATA_W-1:0] rf_writedata;
    logic [ADDR_W-1:0] rd_rega;
    logic [ADDR_W-1:0] rd_regb;
    logic [DATA_W-1:0] rf_read1;
    logic [DATA_W-1:0] rf_read2;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic              hit_a;
    logic              hit_b;

    modport slave (
        input  in_valid, in_reg, in_data, rf_stall,
        input  rd_rega, rd_regb, rf_read1, rf_read2,
        output in_ready, rf_write_en, rf_wreg, rf_writedata,
        output read1, read2, hit_a, hit_b
    );

    modport master (
        output in_valid, in_reg, in_data, rf_stall,
        output rd_rega, rd_regb, rf_read1, rf_read2,
        input  in_ready, rf_write_en, rf_wreg, rf_writedata,
        input  read1, read2, hit_a, hit_b
    );

endinterface

// File: rtl/wb_write_queue_fwd_mux.sv
// Youngest-match forwarding select for one read port.
// Entries arrive ordered oldest (index 0) to youngest, so the last match wins.
module wbq_fwd_mux
    import wbq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wbq_entry_t [DEPTH-1:0] entries_i,
    input  logic [ADDR_W-1:0]      rreg_i,
    input  logic [DATA_W-1:0]      rf_data_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   hit_o
);

    always_comb begin
        data_o = rf_data_i;
        hit_o  = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (entries_i[k].valid && (entries_i[k].rreg == rreg_i)) begin
                data_o = entries_i[k].data;
                hit_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback write queue with read-path forwarding.
// Define WBQ_COALESCE_EN to merge a push into the youngest entry for the same register.
module wb_write_queue
    import wbq_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = wbq_pkg::DATA_W,
    parameter int unsigned ADDR_W = wbq_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_write_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbq_entry_t [DEPTH-1:0] mem_q, mem_d;
    wbq_entry_t [DEPTH-1:0] age_ord;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [PTR_W-1:0]       young_idx;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   empty, full, push, pop, coalesce;
    wbq_entry_t             head_e;
    logic [ADDR_W-1:0]      wreg;
    logic [DATA_W-1:0]      wdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = bus.in_valid && !full;
    assign pop       = !empty && !bus.rf_stall;
    assign head_e    = mem_q[head_q];
    assign young_idx = tail_q - PTR_W'(1);

`ifdef WBQ_COALESCE_EN
    // A youngest entry that is also the head being popped has already left the queue.
    assign coalesce = push && !empty && (mem_q[young_idx].rreg == bus.in_reg)
                      && !(pop && (count_q == CNT_W'(1)));
`else
    assign coalesce = 1'b0;
`endif

    assign wreg  = empty ? '0 : head_e.rreg;
    assign wdata = empty ? '0 : head_e.data;

    assign bus.in_ready     = !full;
    assign bus.rf_write_en  = pop;
    assign bus.rf_wreg      = wreg;
    assign bus.rf_writedata = wdata;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end
        if (push) begin
            if (coalesce) begin
                mem_d[young_idx].data = bus.in_data;
            end else begin
                mem_d[tail_q].valid = 1'b1;
                mem_d[tail_q].rreg  = bus.in_reg;
                mem_d[tail_q].data  = bus.in_data;
                tail_d              = tail_q + PTR_W'(1);
            end
        end
        case ({push && !coalesce, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Oldest-first view; the head stays in it while its write is in flight.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            age_ord[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    wbq_fwd_mux #(.DEPTH(DEPTH)) u_fwd_a (
        .entries_i (age_ord),
        .rreg_i    (bus.rd_rega),
        .rf_data_i (bus.rf_read1),
        .data_o    (bus.read1),
        .hit_o     (bus.hit_a)
    );

    wbq_fwd_mux #(.DEPTH(DEPTH)) u_fwd_b (
        .entries_i (age_ord),
        .rreg_i    (bus.rd_regb),
        .rf_data_i (bus.rf_read2),
        .data_o    (bus.read2),
        .hit_o     (bus.hit_b)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted requests queue expected writes,
// a negedge monitor checks every register file write against them.
module tb_wb_write_queue;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    int   w;

`ifdef WBQ_COALESCE_EN
    localparam bit COALESCE_ON = 1'b1;
`else
    localparam bit COALESCE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_write_queue_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    wb_write_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT issues must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rf_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write at %0t",
                         bus.rf_wreg, bus.rf_writedata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_reg_data", {13'd0, bus.rf_wreg, bus.rf_writedata}, {13'd0, e.r, e.d});
            end
        end
    end

    // Hold a request until accepted; returns the number of cycles it was refused.
    task automatic push(input logic [2:0] r, input logic [15:0] d, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_reg   = r;
        bus.in_data  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                #1;
                if (COALESCE_ON && exp_q.size() > 0 && exp_q[exp_q.size()-1].r == r) begin
                    exp_q[exp_q.size()-1].d = d;
                end else begin
                    exp_q.push_back('{r: r, d: d});
                end
            end else begin
                waited++;
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_reg   = '0;
        bus.in_data  = '0;
        bus.rf_stall = 1'b0;
        bus.rd_rega  = 3'd0;
        bus.rd_regb  = 3'd0;
        bus.rf_read1 = 16'h0001;
        bus.rf_read2 = 16'h0002;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("idle_write_en", {31'd0, bus.rf_write_en}, 32'd0);
        chk("idle_wreg", {29'd0, bus.rf_wreg}, 32'd0);
        chk("idle_wdata", {16'd0, bus.rf_writedata}, 32'd0);
        chk("idle_read1", {16'd0, bus.read1}, 32'h0001);
        chk("idle_hit_a", {31'd0, bus.hit_a}, 32'd0);
        @(posedge clk);
        #1;

        // Single write, forwarded while the head is being written
        push(3'd3, 16'hBEEF, w);
        bus.rd_rega = 3'd3;
        @(negedge clk);
        chk("single_read1", {16'd0, bus.read1}, 32'hBEEF);
        chk("single_hit_a", {31'd0, bus.hit_a}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_commit_read1", {16'd0, bus.read1}, 32'h0001);
        chk("after_commit_hit_a", {31'd0, bus.hit_a}, 32'd0);
        @(posedge clk);
        #1;

        // Fill under stall, hold a 5th request, then release
        bus.rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(3'(i), 16'h1000 + 16'(i), w);
        bus.rd_rega = 3'd2;
        @(negedge clk);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_fwd_read1", {16'd0, bus.read1}, 32'h1002);
        bus.in_valid = 1'b1;
        bus.in_reg   = 3'd6;
        bus.in_data  = 16'h6666;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("held_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.rf_stall = 1'b0;
        push(3'd6, 16'h6666, w);
        chk("full_accept_delay", w, 32'd1);
        wait_empty();

        // Youngest match wins
        bus.rf_stall = 1'b1;
        push(3'd5, 16'h1111, w);
        push(3'd5, 16'h2222, w);
        bus.rd_regb = 3'd5;
        bus.rd_rega = 3'd5;
        @(negedge clk);
        chk("young_read2", {16'd0, bus.read2}, 32'h2222);
        chk("young_hit_b", {31'd0, bus.hit_b}, 32'd1);
        chk("young_read1", {16'd0, bus.read1}, 32'h2222);
        bus.rd_regb = 3'd7;
        #1;
        chk("miss_read2", {16'd0, bus.read2}, 32'h0002);
        chk("miss_hit_b", {31'd0, bus.hit_b}, 32'd0);
        @(posedge clk);
        #1;
        bus.rf_stall = 1'b0;
        wait_empty();

        // Continuous push while draining at a depth of two, across pointer wraps
        bus.rf_stall = 1'b1;
        push(3'd0, 16'hA000, w);
        push(3'd1, 16'hA003, w);
        bus.rf_stall = 1'b0;
        for (int i = 2; i < 22; i++) begin
            push(3'(i % 8), 16'hA000 + 16'(i * 3), w);
            chk("stream_no_wait", w, 32'd0);
        end
        wait_empty();

        // Reset with writes pending discards them
        bus.rf_stall = 1'b1;
        for (int i = 2; i <= 5; i++) push(3'(i), 16'hC000 + 16'(i), w);
        bus.rf_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        bus.rd_rega = 3'd3;
        #1;
        chk("rst_write_en", {31'd0, bus.rf_write_en}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_wreg", {29'd0, bus.rf_wreg}, 32'd0);
        chk("rst_hit_a", {31'd0, bus.hit_a}, 32'd0);
        chk("rst_read1", {16'd0, bus.read1}, 32'h0001);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        push(3'd7, 16'h7777, w);
        wait_empty();
        chk("pending_at_end", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writeback-side initiator for the 8x16 register file: accepts register write requests from the execute/memory stages over a valid/ready handshake.
- Buffers requests in a small in-order FIFO and drives the register file write port (write enable, write address, write data) at most one write per cycle.
- Forwards pending, not-yet-committed data onto both read paths, so decode always sees the architecturally newest value.

Parameters:
- DEPTH, 4, number of queue entries (power of two, at least 2)
- DATA_W, 16, register data width
- ADDR_W, 3, register index width (8 registers)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a write request
- in_ready  output  1  queue can accept a request this cycle
- in_reg  input  ADDR_W  destination register of the request
- in_data  input  DATA_W  write data of the request
- rf_stall  input  1  hold off draining this cycle (debug/single-step)
- rf_write_en  output  1  to register file write enable
- rf_wreg  output  ADDR_W  to register file write address
- rf_writedata  output  DATA_W  to register file write data
- rd_rega  input  ADDR_W  read address 1 currently presented to the register file
- rd_regb  input  ADDR_W  read address 2 currently presented to the register file
- rf_read1  input  DATA_W  raw read data 1 from the register file
- rf_read2  input  DATA_W  raw read data 2 from the register file
- read1  output  DATA_W  forwarded read data 1
- read2  output  DATA_W  forwarded read data 2
- hit_a  output  1  read1 was sourced from the queue
- hit_b  output  1  read2 was sourced from the queue

Behaviour:
- Reset (async, rst_n low): head=0, tail=0, count=0, all entry valid bits cleared. Outputs after reset: rf_write_en=0, rf_wreg=0, rf_writedata=0, in_ready=1, hit_a=hit_b=0, read1/read2 pass rf_read1/rf_read2 through.
- Reset asserted mid-operation discards all pending writes; no partial write is issued.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH). There is no same-cycle pass-through when full, even if a pop happens in the same cycle. A request is held by the producer until accepted.
- Drain: rf_write_en = (count != 0) && !rf_stall. rf_wreg and rf_writedata come from the head entry; they are driven to 0 when the queue is empty.
- Pop: occurs on every cycle rf_write_en=1. The register file captures the write at the same clock edge, so write latency from acceptance is at least 1 cycle when the queue is empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Writes commit strictly in acceptance order.
- Forwarding (combinational):
  - For each read port, search all valid entries for a register match; the youngest matching entry wins.
  - The head entry being written this cycle is included in the search, because the register file still returns the old value until the edge.
  - On a match, readN takes the entry data and hit_N=1; otherwise readN = rf_readN and hit_N=0.
  - The in_data of a request being pushed this cycle is never forwarded.
- Register 0 has no special treatment; it is writable like any other register.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined: on push, if the youngest valid entry has the same in_reg and is not being popped this cycle, its data is overwritten in place. No new entry is allocated and count does not change. in_ready is still full-based.
- Not defined: every accepted request allocates an entry; the register file sees every write.

Decomposition:
- Shared package wbq_pkg: DATA_W, ADDR_W, NUM_REGS=8 constants, and the entry typedef {valid, reg index, data}.
- One sub-module, wbq_fwd_mux: youngest-match priority select for one read port, instantiated twice.

Test Plan:
- Reset then idle: after rst_n rises, in_ready=1, rf_write_en=0, rf_wreg=0, rf_writedata=0, and read1 tracks rf_read1 = 0x0001.
- Single write: push reg3=0xBEEF at cycle 0 -> cycle 1 has rf_write_en=1, rf_wreg=3, rf_writedata=0xBEEF; with rd_rega=3 in cycle 1, read1=0xBEEF and hit_a=1.
- Fill under stall: with rf_stall=1, push 4 writes to reg1..4 -> in_ready=0 after the 4th; a 5th request is held. Release the stall -> writes commit in order 1,2,3,4, and the 5th is accepted the cycle after count drops below 4.
- Youngest forwarding: with rf_stall=1, push reg5=0x1111 then reg5=0x2222 -> rd_regb=5 gives read2=0x2222 and hit_b=1.
- Same-cycle push/pop: at count=2, push while draining -> count stays 2, with no lost or duplicated write across a pointer wrap (20 random requests checked against a reference model).
- Reset mid-drain: assert rst_n low with 3 entries pending -> rf_write_en=0 immediately; no further writes after release.
- With WBQ_COALESCE_EN, the two reg5 pushes above under stall occupy one entry (count=1), and exactly one write of 0x2222 is issued.
